// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline types: datapath widths, hazard controller state and per-register control.
// Types only; no logic, no latency.
package pipes;
  typedef logic [63:0] u64;
  typedef logic [31:0] u32;
  typedef logic [4:0]  creg_addr_t;

  typedef enum logic {CTRL_IDLE, CTRL_HOLD} ctrl_state_t;

  typedef struct packed {
    logic stall;
    logic flush;
  } reg_ctrl_t;

  localparam reg_ctrl_t REG_RUN = '{stall: 1'b0, flush: 1'b0};
endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Flags a decode instruction that reads the destination of a load still in execute.
// Purely combinational, zero latency; x0 never creates a dependency.
module load_use_detect
  import pipes::*;
(
  input  logic       d_valid,
  input  creg_addr_t d_rs1,
  input  creg_addr_t d_rs2,
  input  logic       e_is_load,
  input  creg_addr_t e_rd,
  output logic       load_use
);
  assign load_use = d_valid & e_is_load & (e_rd != '0) & ((e_rd == d_rs1) | (e_rd == d_rs2));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the F/D/E/M/W registers and fetch PC, with redirect hold and perf counters.
// Controls are combinational from inputs and state; a redirect that meets i_busy waits in HOLD.
module pipe_hazard_ctrl
  import pipes::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_busy,
  input  logic       d_busy,
  input  logic       x_busy,
  input  logic       d_valid,
  input  creg_addr_t d_rs1,
  input  creg_addr_t d_rs2,
  input  logic       e_is_load,
  input  creg_addr_t e_rd,
  input  logic       redirect,
  input  u64         redirect_pc,
  output logic       pc_stall,
  output logic       stall_fd,
  output logic       flush_fd,
  output logic       stall_de,
  output logic       flush_de,
  output logic       stall_em,
  output logic       flush_em,
  output logic       stall_mw,
  output logic       flush_mw,
  output logic       pc_redirect_valid,
  output u64         pc_redirect,
  output u32         stall_cycles,
  output u32         flush_count
);
  ctrl_state_t state_q, state_d, state_eff;
  u64          hold_pc_q, hold_pc_d;
  u32          stall_cycles_q, stall_cycles_d;
  u32          flush_count_q, flush_count_d;
  reg_ctrl_t   ctl_fd, ctl_de, ctl_em, ctl_mw;
  logic        load_use;
  logic        redirect_take;

  load_use_detect u_load_use (
    .d_valid   (d_valid),
    .d_rs1     (d_rs1),
    .d_rs2     (d_rs2),
    .e_is_load (e_is_load),
    .e_rd      (e_rd),
    .load_use  (load_use)
  );

  // Reset drops any pending redirect immediately, so outputs follow IDLE rules while it is high.
  assign state_eff     = reset ? CTRL_IDLE : state_q;
  assign redirect_take = (state_eff == CTRL_IDLE) & redirect & ~d_busy & ~x_busy;

  always_ff @(posedge clk) begin
    state_q        <= state_d;
    hold_pc_q      <= hold_pc_d;
    stall_cycles_q <= stall_cycles_d;
    flush_count_q  <= flush_count_d;
  end

  always_comb begin
    state_d        = state_q;
    hold_pc_d      = hold_pc_q;
    stall_cycles_d = stall_cycles_q + u32'(pc_stall);
    flush_count_d  = flush_count_q + u32'(pc_redirect_valid);
    unique case (state_q)
      CTRL_IDLE: begin
        if (redirect_take && i_busy) begin
          state_d   = CTRL_HOLD;
          hold_pc_d = redirect_pc;
        end
      end
      CTRL_HOLD: begin
        if (!i_busy) state_d = CTRL_IDLE;
      end
      default: state_d = CTRL_IDLE;
    endcase
    if (reset) begin
      state_d        = CTRL_IDLE;
      hold_pc_d      = '0;
      stall_cycles_d = '0;
      flush_count_d  = '0;
    end
  end

  always_comb begin
    pc_stall          = 1'b0;
    pc_redirect_valid = 1'b0;
    pc_redirect       = '0;
    ctl_fd            = REG_RUN;
    ctl_de            = REG_RUN;
    ctl_em            = REG_RUN;
    ctl_mw            = REG_RUN;
    unique case (state_eff)
      CTRL_IDLE: begin
        if (d_busy) begin
          pc_stall     = 1'b1;
          ctl_fd.stall = 1'b1;
          ctl_de.stall = 1'b1;
          ctl_em.stall = 1'b1;
          ctl_mw.flush = 1'b1;
        end else if (x_busy) begin
          pc_stall     = 1'b1;
          ctl_fd.stall = 1'b1;
          ctl_de.stall = 1'b1;
          ctl_em.flush = 1'b1;
        end else if (redirect) begin
          // Redirect outranks load-use: whatever sits in D is wrong-path.
          ctl_fd.flush = 1'b1;
          ctl_de.flush = 1'b1;
          if (!i_busy) begin
            pc_redirect_valid = 1'b1;
            pc_redirect       = redirect_pc;
          end else begin
            pc_stall = 1'b1;
          end
        end else if (load_use) begin
          pc_stall     = 1'b1;
          ctl_fd.stall = 1'b1;
          ctl_de.flush = 1'b1;
        end else if (i_busy) begin
          pc_stall     = 1'b1;
          ctl_fd.flush = 1'b1;
        end
      end
      CTRL_HOLD: begin
        ctl_fd.flush = 1'b1;
        if (d_busy) begin
          pc_stall     = 1'b1;
          ctl_de.stall = 1'b1;
          ctl_em.stall = 1'b1;
          ctl_mw.flush = 1'b1;
        end else if (x_busy) begin
          pc_stall     = 1'b1;
          ctl_de.stall = 1'b1;
          ctl_em.flush = 1'b1;
        end
        if (i_busy) begin
          pc_stall = 1'b1;
        end else begin
          pc_redirect_valid = 1'b1;
          pc_redirect       = hold_pc_q;
        end
      end
      default: ;
    endcase
  end

  assign {stall_fd, flush_fd} = ctl_fd;
  assign {stall_de, flush_de} = ctl_de;
  assign {stall_em, flush_em} = ctl_em;
  assign {stall_mw, flush_mw} = ctl_mw;
  assign stall_cycles         = stall_cycles_q;
  assign flush_count          = flush_count_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected controls queued with each stimulus step,
// popped and compared once the combinational outputs settle; counters checked at known points.
module tb_pipe_hazard_ctrl;
  import pipes::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_busy, d_busy, x_busy, d_valid, e_is_load, redirect;
  creg_addr_t d_rs1, d_rs2, e_rd;
  u64         redirect_pc;
  logic       pc_stall, stall_fd, flush_fd, stall_de, flush_de, stall_em, flush_em;
  logic       stall_mw, flush_mw, pc_redirect_valid;
  u64         pc_redirect;
  u32         stall_cycles, flush_count;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .i_busy(i_busy), .d_busy(d_busy), .x_busy(x_busy),
    .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2), .e_is_load(e_is_load), .e_rd(e_rd),
    .redirect(redirect), .redirect_pc(redirect_pc), .pc_stall(pc_stall),
    .stall_fd(stall_fd), .flush_fd(flush_fd), .stall_de(stall_de), .flush_de(flush_de),
    .stall_em(stall_em), .flush_em(flush_em), .stall_mw(stall_mw), .flush_mw(flush_mw),
    .pc_redirect_valid(pc_redirect_valid), .pc_redirect(pc_redirect),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // Control vector bit positions.
  localparam logic [9:0] PS  = 10'b10_0000_0000;
  localparam logic [9:0] SFD = 10'b01_0000_0000;
  localparam logic [9:0] FFD = 10'b00_1000_0000;
  localparam logic [9:0] SDE = 10'b00_0100_0000;
  localparam logic [9:0] FDE = 10'b00_0010_0000;
  localparam logic [9:0] SEM = 10'b00_0001_0000;
  localparam logic [9:0] FEM = 10'b00_0000_1000;
  localparam logic [9:0] FMW = 10'b00_0000_0010;
  localparam logic [9:0] PRV = 10'b00_0000_0001;

  typedef struct {
    string      tag;
    logic [9:0] ctl;
    u64         pc;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [9:0] obs_ctl;

  assign obs_ctl = {pc_stall, stall_fd, flush_fd, stall_de, flush_de,
                    stall_em, flush_em, stall_mw, flush_mw, pc_redirect_valid};

  // Redirect must never be presented while a redirect is already pending.
  always @(negedge clk) begin
    if (!reset && dut.state_q == CTRL_HOLD) begin
      assert (redirect !== 1'b1) else begin
        errors++;
        $error("FAIL redirect_in_hold observed=%b expected=0", redirect);
      end
    end
  end

  // Called with inputs already driven at a negedge: queue the expectation, let outputs
  // settle, pop and compare, then advance to the next negedge.
  task automatic step(input string tag, input logic [9:0] ctl, input u64 pc);
    exp_t e;
    sb.push_back('{tag: tag, ctl: ctl, pc: pc});
    #1;
    e = sb.pop_front();
    checks++;
    assert (obs_ctl === e.ctl) else begin
      errors++;
      $error("FAIL %s ctl observed=%b expected=%b", e.tag, obs_ctl, e.ctl);
    end
    checks++;
    assert (pc_redirect === e.pc) else begin
      errors++;
      $error("FAIL %s pc_redirect observed=%h expected=%h", e.tag, pc_redirect, e.pc);
    end
    @(negedge clk);
  endtask

  task automatic check_cnt(input string tag, input u32 exp_stall, input u32 exp_flush);
    checks++;
    assert (stall_cycles === exp_stall) else begin
      errors++;
      $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, stall_cycles, exp_stall);
    end
    checks++;
    assert (flush_count === exp_flush) else begin
      errors++;
      $error("FAIL %s flush_count observed=%0d expected=%0d", tag, flush_count, exp_flush);
    end
  endtask

  task automatic idle_inputs();
    i_busy = 0; d_busy = 0; x_busy = 0; d_valid = 0; e_is_load = 0; redirect = 0;
    d_rs1 = '0; d_rs2 = '0; e_rd = '0; redirect_pc = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    step("reset_outputs", '0, '0);
    reset = 1'b0;
    step("post_reset_idle", '0, '0);
    check_cnt("reset_counters", 0, 0);

    // Load-use via rs2, then the same with x0 as destination.
    d_valid = 1; e_is_load = 1; e_rd = 5; d_rs2 = 5;
    step("load_use_rs2", PS | SFD | FDE, '0);
    e_rd = 0; d_rs2 = 0;
    step("load_use_x0", '0, '0);
    e_rd = 7; d_rs1 = 7; d_rs2 = 3;
    step("load_use_rs1", PS | SFD | FDE, '0);
    d_valid = 0;
    step("load_use_no_valid", '0, '0);
    check_cnt("after_load_use", 2, 0);

    // Immediate redirect, with a load-use present that it must override.
    d_valid = 1; redirect = 1; redirect_pc = 64'h8000_0040;
    step("redirect_now", FFD | FDE | PRV, 64'h8000_0040);
    idle_inputs();
    step("after_redirect_idle", '0, '0);
    check_cnt("redirect_now_cnt", 2, 1);

    // Redirect under a 3-cycle ibus wait: pulse on the 4th cycle with the latched target.
    redirect = 1; redirect_pc = 64'h8000_1000; i_busy = 1;
    step("hold_accept", PS | FFD | FDE, '0);
    redirect = 0; redirect_pc = 64'hDEAD_BEEF_0000_0000;
    step("hold_wait1", PS | FFD, '0);
    step("hold_wait2", PS | FFD, '0);
    i_busy = 0;
    step("hold_release", FFD | PRV, 64'h8000_1000);
    idle_inputs();
    step("after_hold_idle", '0, '0);
    check_cnt("hold_cnt", 5, 2);

    // dbus wait blocks a redirect; it is accepted once d_busy drops.
    d_busy = 1; redirect = 1; redirect_pc = 64'h8000_2000;
    step("dbusy_vs_redirect", PS | SFD | SDE | SEM | FMW, '0);
    d_busy = 0;
    step("redirect_after_dbusy", FFD | FDE | PRV, 64'h8000_2000);
    idle_inputs();

    // x_busy outranks load-use; i_busy alone bubbles F->D.
    x_busy = 1; d_valid = 1; e_is_load = 1; e_rd = 9; d_rs1 = 9;
    step("xbusy_vs_load_use", PS | SFD | SDE | FEM, '0);
    idle_inputs();
    i_busy = 1;
    step("ibusy_only", PS | FFD, '0);
    i_busy = 0; x_busy = 1; redirect = 1; redirect_pc = 64'h8000_2222;
    step("xbusy_vs_redirect", PS | SFD | SDE | FEM, '0);
    idle_inputs();
    check_cnt("mixed_cnt", 9, 3);

    // dbus wait during HOLD keeps F->D flushing, never stalled.
    redirect = 1; redirect_pc = 64'h8000_3000; i_busy = 1;
    step("hold2_accept", PS | FFD | FDE, '0);
    redirect = 0; d_busy = 1;
    step("hold2_dbusy", PS | FFD | SDE | SEM | FMW, '0);
    i_busy = 0; d_busy = 0;
    step("hold2_release", FFD | PRV, 64'h8000_3000);
    check_cnt("hold2_cnt", 11, 4);

    // Reset in the middle of HOLD drops the pending redirect.
    redirect = 1; redirect_pc = 64'h8000_4000; i_busy = 1;
    step("hold3_accept", PS | FFD | FDE, '0);
    redirect = 0; reset = 1;
    step("hold3_reset", PS | FFD, '0);
    reset = 0;
    check_cnt("hold3_reset_cnt", 0, 0);
    step("hold3_post_reset_ibusy", PS | FFD, '0);
    i_busy = 0;
    step("hold3_no_pulse", '0, '0);
    check_cnt("hold3_final_cnt", 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
